dcache: RTL and testbench
=========================

Name: dcache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Responds to the load/store unit's dcache request interface: level-held rreq/wreq with addr, wdata and byte_enable. Returns one-cycle rvalid/wvalid pulses and LSB-aligned rdata.
- Misses and all stores go to the data-memory port through a req/ack handshake.
- Sits between the core's LSU and the memory/bus arbiter.

Parameters:
- LINES, 64, number of one-word cache lines (power of two); IDX_W = log2(LINES).
- ADDR_W, 32, byte address width; tag = addr[ADDR_W-1 : IDX_W+2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- dcache_addr  in  32  byte address from LSU
- dcache_wreq  in  1  write request, level, held until wvalid
- dcache_rreq  in  1  read request, level, held until rvalid
- dcache_wdata  in  32  store data, LSB-aligned
- dcache_byte_enable  in  4  LSB-relative byte mask (0001/0011/1111)
- dcache_wvalid  out  1  store complete, one-cycle pulse
- dcache_rdata  out  32  load data, LSB-aligned, valid while rvalid=1
- dcache_rvalid  out  1  load complete, one-cycle pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address (low 2 bits 0)
- mem_wdata  out  32  lane-positioned write data
- mem_be  out  4  lane-positioned byte strobes
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle completion

Behaviour:
- Reset: all valid bits cleared, FSM=IDLE, every output 0. Reset dominates any state. An outstanding mem_req drops the cycle after rst; the memory side discards it.
- Lane alignment, with off = addr[1:0]:
  - Effective mask: be_eff = (byte_enable << off) truncated to 4 bits.
  - Write data: wdata << 8*off.
  - Read data: rdata = line_word >> 8*off.
  - Bytes pushed past lane 3 (misaligned access) are dropped silently. Sign/zero extension stays in the LSU.
- FSM states: IDLE, RD_MISS, WR_MEM, RESP.
- IDLE:
  - wreq has priority over rreq if both are asserted.
  - wreq with be_eff==0 -> RESP (no memory write).
  - wreq otherwise:
    - If hit, merge be_eff bytes into the line this cycle.
    - Latch addr, data and mask, then -> WR_MEM.
  - rreq, hit -> register the shifted word into rdata, -> RESP.
  - rreq, miss -> latch addr, -> RD_MISS.
  - Neither request -> stay in IDLE.
- RD_MISS:
  - mem_req=1, mem_we=0, mem_be=1111.
  - On mem_ack: write mem_rdata into the line, set valid, load the tag, register the shifted mem_rdata into rdata, -> RESP.
- WR_MEM:
  - mem_req=1, mem_we=1, strobes = latched be_eff.
  - On mem_ack -> RESP.
  - A store miss does not allocate.
- RESP:
  - rvalid or wvalid = 1 for exactly one cycle, matching the request type.
  - -> IDLE unconditionally.
  - Requests are ignored in RESP.
  - A request still asserted in the following IDLE cycle is a new access (back-to-back or stalled). A repeated store is idempotent.
- Latency: hit load responds 1 cycle after the request is sampled. A miss or store takes 1 cycle + memory latency + 1 cycle.
- Memory request outputs stay stable while mem_req=1 and not yet acked. mem_ack while idle is ignored.
- dcache_rdata holds its last value outside RESP.

Decomposition:
- type_pkg: reuse addr_t, data_t, byte_en_t.
- type_pkg additions:
  - dcache_state_t enum (IDLE, RD_MISS, WR_MEM, RESP)
  - constant DCACHE_LINES
  - function lane_shift for mask/data positioning
- Sub-module dcache_array:
  - valid/tag/data storage with combinational read and synchronous byte-masked write port.
  - Fill-write and hit-merge share this one port.
  - Valid clear on rst.

Test Plan:
- Cold load: rreq addr 0x100, mem returns 0xDEADBEEF after 3 cycles -> one mem_req at 0x100. rvalid pulses 1 cycle after ack with rdata 0xDEADBEEF. Repeat rreq -> no mem_req, rvalid 1 cycle later.
- Byte store hit: line 0x100 holds 0xDEADBEEF; wreq addr 0x102, be 0001, wdata 0x000000AA -> mem_be 0100, mem_wdata 0x00AA0000, wvalid after ack. Subsequent lw 0x100 hits with 0xDEAABEEF.
- Store miss no-allocate: wreq 0x200 word 0x12345678 -> mem write. Next rreq 0x200 still misses and issues mem_req.
- Halfword load offset: line 0x100 = 0x11223344; rreq 0x102 be 0011 -> rdata 0x00001122.
- Conflict eviction: load 0x100, then load 0x100+4*LINES -> second misses, replaces the line. Reload of 0x100 misses again.
- Reset mid-miss: rst during RD_MISS -> next cycle mem_req=0, state IDLE, all outputs 0. Previously cached 0x100 now misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through L1 data cache.
// lane_shift/mask_shift move LSB-aligned LSU data and strobes onto the byte lanes selected by addr[1:0].
package dcache_pkg;

  localparam int DCACHE_LINES = 64;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2,
    RESP    = 2'd3
  } dcache_state_t;

  // Bytes pushed past lane 3 fall off the top and are dropped.
  function automatic data_t lane_shift(input data_t d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic byte_en_t mask_shift(input byte_en_t be, input logic [1:0] off);
    return be << off;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read, one synchronous byte-masked write port.
// Any write (fill or hit merge) marks the line valid and reloads its tag.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = DCACHE_LINES,
  parameter int TAG_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [31:0]              rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_be
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  data_t            data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache between the LSU and memory.
// Handshake: LSU holds rreq/wreq until a one-cycle rvalid/wvalid; mem_req and its fields stay stable until a one-cycle mem_ack.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES  = DCACHE_LINES,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_wreq,
  input  logic              dcache_rreq,
  input  logic [31:0]       dcache_wdata,
  input  logic [3:0]        dcache_byte_enable,
  output logic              dcache_wvalid,
  output logic [31:0]       dcache_rdata,
  output logic              dcache_rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  dcache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  data_t             wdata_q;
  byte_en_t          be_q;
  logic              is_wr_q;
  data_t             rdata_q;

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  byte_en_t         be_eff;
  logic             hit;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  data_t            rd_data;
  logic             arr_we;
  logic [IDX_W-1:0] arr_idx;
  logic [TAG_W-1:0] arr_tag;
  data_t            arr_data;
  byte_en_t         arr_be;

  assign off    = dcache_addr[1:0];
  assign idx    = dcache_addr[IDX_W+1:2];
  assign tag    = dcache_addr[ADDR_W-1:IDX_W+2];
  assign be_eff = mask_shift(dcache_byte_enable, off);
  assign hit    = rd_valid && (rd_tag == tag);

  assign dcache_rdata = rdata_q;
  assign dbg_state    = state_q;

  dcache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we && !rst),
    .wr_idx   (arr_idx),
    .wr_tag   (arr_tag),
    .wr_data  (arr_data),
    .wr_be    (arr_be)
  );

  always_comb begin
    state_d       = state_q;
    arr_we        = 1'b0;
    arr_idx       = idx;
    arr_tag       = tag;
    arr_data      = lane_shift(dcache_wdata, off);
    arr_be        = be_eff;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_be        = '0;
    dcache_rvalid = 1'b0;
    dcache_wvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (dcache_wreq) begin
          if (be_eff == 4'b0000) begin
            state_d = RESP;
          end else begin
            arr_we  = hit;
            state_d = WR_MEM;
          end
        end else if (dcache_rreq) begin
          state_d = hit ? RESP : RD_MISS;
        end
      end
      RD_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        mem_be   = 4'hF;
        arr_idx  = addr_q[IDX_W+1:2];
        arr_tag  = addr_q[ADDR_W-1:IDX_W+2];
        arr_data = mem_rdata;
        arr_be   = 4'hF;
        if (mem_ack) begin
          arr_we  = 1'b1;
          state_d = RESP;
        end
      end
      WR_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_q;
        mem_be    = be_q;
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        dcache_rvalid = !is_wr_q;
        dcache_wvalid = is_wr_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (dcache_wreq) begin
          addr_q  <= dcache_addr;
          wdata_q <= lane_shift(dcache_wdata, off);
          be_q    <= be_eff;
          is_wr_q <= 1'b1;
        end else if (dcache_rreq) begin
          addr_q  <= dcache_addr;
          is_wr_q <= 1'b0;
          if (hit) rdata_q <= rd_data >> {off, 3'b000};
        end
      end else if (state_q == RD_MISS && mem_ack) begin
        rdata_q <= mem_rdata >> {addr_q[1:0], 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a latency-programmable memory responder plus load/store driver tasks.
// Expected load data is queued when a load is driven and compared when rvalid pulses.
module tb_dcache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dcache_addr;
  logic        dcache_wreq;
  logic        dcache_rreq;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_byte_enable;
  logic        dcache_wvalid;
  logic [31:0] dcache_rdata;
  logic        dcache_rvalid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem_arr [logic [31:0]];
  int          mem_lat = 3;
  int          txn_cnt = 0;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic        txn_we;
  logic [3:0]  txn_be;

  always #5 clk = ~clk;

  dcache dut (
    .clk                (clk),
    .rst                (rst),
    .dcache_addr        (dcache_addr),
    .dcache_wreq        (dcache_wreq),
    .dcache_rreq        (dcache_rreq),
    .dcache_wdata       (dcache_wdata),
    .dcache_byte_enable (dcache_byte_enable),
    .dcache_wvalid      (dcache_wvalid),
    .dcache_rdata       (dcache_rdata),
    .dcache_rvalid      (dcache_rvalid),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_be             (mem_be),
    .mem_rdata          (mem_rdata),
    .mem_ack            (mem_ack),
    .dbg_state          (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks mem_lat cycles after mem_req is seen, checks request stability meanwhile.
  initial begin
    int         cnt;
    bit         held;
    logic [68:0] hold_v;
    logic [68:0] cur;
    logic [31:0] w;
    cnt = 0;
    held = 0;
    hold_v = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      cur = {mem_addr, mem_we, mem_be, mem_wdata};
      if (mem_ack) begin
        mem_ack = 1'b0;
        held = 0;
        cnt = 0;
      end else if (rst || !mem_req) begin
        held = 0;
        cnt = 0;
      end else begin
        if (held) check("mem_stable", 32'(cur === hold_v), 32'd1);
        hold_v = cur;
        held = 1;
        if (cnt >= mem_lat) begin
          w = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
              if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem_arr[mem_addr] = w;
          end else begin
            mem_rdata = w;
          end
          txn_addr  = mem_addr;
          txn_we    = mem_we;
          txn_be    = mem_be;
          txn_wdata = mem_wdata;
          txn_cnt++;
          mem_ack = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic do_load(input string tag, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] exp_d, input bit exp_miss);
    int t0;
    int cyc;
    bit done;
    t0 = txn_cnt;
    dcache_addr = a;
    dcache_byte_enable = be;
    dcache_rreq = 1'b1;
    exp_q.push_back(exp_d);
    cyc = 0;
    done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dcache_rvalid) done = 1;
    end
    dcache_rreq = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_rdata"}, dcache_rdata, exp_q.pop_front());
    check({tag, "_txns"}, 32'(txn_cnt - t0), 32'(exp_miss));
    if (exp_miss) begin
      check({tag, "_mem_addr"}, txn_addr, {a[31:2], 2'b00});
      check({tag, "_mem_rd"}, {27'd0, txn_we, txn_be}, 32'h0000000F);
    end else begin
      check({tag, "_latency"}, 32'(cyc), 32'd1);
    end
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, dcache_rvalid, dcache_wvalid}, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input bit exp_txn);
    int t0;
    int cyc;
    bit done;
    t0 = txn_cnt;
    dcache_addr = a;
    dcache_byte_enable = be;
    dcache_wdata = wd;
    dcache_wreq = 1'b1;
    cyc = 0;
    done = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dcache_wvalid) done = 1;
    end
    dcache_wreq = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_txns"}, 32'(txn_cnt - t0), 32'(exp_txn));
    if (exp_txn) begin
      check({tag, "_mem_addr"}, txn_addr, {a[31:2], 2'b00});
      check({tag, "_mem_be"}, {27'd0, txn_we, txn_be}, {27'd0, 1'b1, exp_be});
      check({tag, "_mem_wdata"}, txn_wdata, exp_wd);
    end else begin
      check({tag, "_latency"}, 32'(cyc), 32'd1);
    end
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, dcache_rvalid, dcache_wvalid}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_ctl"}, {24'd0, mem_req, mem_we, dcache_rvalid, dcache_wvalid, mem_be}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, dcache_rdata, 32'd0);
  endtask

  initial begin
    int  cyc;
    rst = 1'b1;
    dcache_addr = '0;
    dcache_wreq = 1'b0;
    dcache_rreq = 1'b0;
    dcache_wdata = '0;
    dcache_byte_enable = '0;
    mem_arr[32'h100] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    mem_lat = 3;
    do_load("cold_load", 32'h100, 4'hF, 32'hDEADBEEF, 1);
    do_load("repeat_hit", 32'h100, 4'hF, 32'hDEADBEEF, 0);
    do_store("byte_store", 32'h102, 4'b0001, 32'h000000AA, 4'b0100, 32'h00AA0000, 1);
    do_load("merged_hit", 32'h100, 4'hF, 32'hDEAABEEF, 0);
    do_store("word_store", 32'h100, 4'hF, 32'h11223344, 4'hF, 32'h11223344, 1);
    do_load("half_off2", 32'h102, 4'b0011, 32'h00001122, 0);

    mem_lat = 1;
    do_store("store_miss", 32'h200, 4'hF, 32'h12345678, 4'hF, 32'h12345678, 1);
    do_load("no_allocate", 32'h200, 4'hF, 32'h12345678, 1);
    do_load("evicted", 32'h100, 4'hF, 32'h11223344, 1);
    do_load("refill_hit", 32'h100, 4'hF, 32'h11223344, 0);

    mem_lat = 0;
    do_store("misalign_st", 32'h103, 4'hF, 32'h12345678, 4'b1000, 32'h78000000, 1);
    do_load("misalign_merge", 32'h100, 4'hF, 32'h78223344, 0);
    do_load("byte_off3", 32'h103, 4'hF, 32'h00000078, 0);
    do_store("be_eff_zero", 32'h104, 4'b0000, 32'hFFFFFFFF, 4'b0000, 32'h0, 0);

    mem_lat = 10;
    dcache_addr = 32'h300;
    dcache_byte_enable = 4'hF;
    dcache_rreq = 1'b1;
    cyc = 0;
    while (dbg_state != RD_MISS && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_miss_reached", 32'(dbg_state), 32'(RD_MISS));
    @(negedge clk);
    rst = 1'b1;
    dcache_rreq = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_miss");
    rst = 1'b0;
    @(negedge clk);
    mem_lat = 2;
    do_load("post_reset_miss", 32'h100, 4'hF, 32'h78223344, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
